// File: rtl/uarch_pkg.sv
// Shared microarchitecture widths and the writeback packet seen by the CDB arbiter.
package uarch_pkg;
  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      data;
  } writeback_packet_t;
endpackage

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit: one-cycle multiply, radix-2 restoring divide.
// Optional MDU_DIV_EARLY_OUT_EN: trivial divides (x/0, overflow, |rs2|>|rs1|) finish in the one-cycle path.
module mdu_unit #(
  parameter int XLEN  = uarch_pkg::XLEN,
  parameter int TAG_W = uarch_pkg::ROB_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [2:0]                    issue_funct3,
  input  logic [XLEN-1:0]               issue_rs1,
  input  logic [XLEN-1:0]               issue_rs2,
  input  logic [TAG_W-1:0]              issue_tag,
  output uarch_pkg::writeback_packet_t  mdu_result,
  input  logic                          mdu_cdb_gnt,
  output logic [2:0]                    dbg_state
);

  // Handshake: an op is taken on a rising edge where issue_valid && issue_ready && !flush;
  // mdu_result is held while valid until the edge that samples mdu_cdb_gnt high.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CNT_W = $clog2(XLEN);

  logic [2:0]       state;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [1:0]       op_f3;
  logic [TAG_W-1:0] op_tag;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic             early_q;
  uarch_pkg::writeback_packet_t res_q;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  logic            accept;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;

  assign issue_ready = (state == S_IDLE);
  assign accept      = issue_valid && issue_ready && !flush;
  assign mag_a_in    = mag(issue_rs1, ~issue_funct3[0]);
  assign mag_b_in    = mag(issue_rs2, ~issue_funct3[0]);
  assign mdu_result  = res_q;
  assign dbg_state   = state;

  // Multiply: sign-extend both operands to 2*XLEN and keep the truncated product.
  logic            a_sgn;
  logic            b_sgn;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign a_sgn   = (op_f3 == 2'b01) || (op_f3 == 2'b10);
  assign b_sgn   = (op_f3 == 2'b01);
  assign ext_a   = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
  assign ext_b   = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
  assign prod    = ext_a * ext_b;
  assign mul_res = (op_f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;

  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign rem_n = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ~trial[XLEN]};

  // Sign fix-up; divide-by-zero bypasses it because the magnitude result has no sign to apply.
  logic            div_sgn;
  logic            b_zero;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  assign div_sgn = ~op_f3[0];
  assign b_zero  = (op_b == '0);
  assign q_fix   = b_zero ? '1 :
                   (div_sgn && (op_a[XLEN-1] ^ op_b[XLEN-1])) ? (~quo + 1'b1) : quo;
  assign r_fix   = b_zero ? op_a : (div_sgn && op_a[XLEN-1]) ? (~rem + 1'b1) : rem;
  assign div_res = op_f3[1] ? r_fix : q_fix;

  logic            early_take;
  logic [XLEN-1:0] early_res;

`ifdef MDU_DIV_EARLY_OUT_EN
  logic ovf_in;
  logic ovf_q;

  assign ovf_in     = ~issue_funct3[0] && (issue_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (issue_rs2 == '1);
  assign early_take = issue_funct3[2] &&
                      ((issue_rs2 == '0) || ovf_in || (mag_b_in > mag_a_in));
  assign ovf_q      = div_sgn && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  // Overflow quotient equals the dividend (0x80000000); |rs2|>|rs1| leaves rs1 as remainder.
  assign early_res  = op_f3[1] ? (ovf_q ? '0 : op_a) :
                      (b_zero ? '1 : (ovf_q ? op_a : '0));
`else
  assign early_take = 1'b0;
  assign early_res  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_f3   <= '0;
      op_tag  <= '0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      early_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      cnt     <= '0;
      early_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a    <= issue_rs1;
            op_b    <= issue_rs2;
            op_f3   <= issue_funct3[1:0];
            op_tag  <= issue_tag;
            quo     <= mag_a_in;
            dvs     <= mag_b_in;
            rem     <= '0;
            cnt     <= '0;
            early_q <= early_take;
            state   <= (!issue_funct3[2] || early_take) ? S_MUL : S_DIV;
          end
        end
        S_MUL: begin
          res_q.valid <= 1'b1;
          res_q.tag   <= op_tag;
          res_q.data  <= early_q ? early_res : mul_res;
          state       <= S_DONE;
        end
        S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          res_q.valid <= 1'b1;
          res_q.tag   <= op_tag;
          res_q.data  <= div_res;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (mdu_cdb_gnt) begin
            res_q <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: latency, results, tag echo, stall, flush and reset.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [5:0]  issue_tag;
  uarch_pkg::writeback_packet_t mdu_result;
  logic        mdu_cdb_gnt;
  logic [2:0]  dbg_state;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif
  localparam int BUDGET = 60;

  mdu_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_funct3 (issue_funct3),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_tag    (issue_tag),
    .mdu_result   (mdu_result),
    .mdu_cdb_gnt  (mdu_cdb_gnt),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[$];

  // Wait (bounded) for mdu_result.valid; returns the cycle count after the accept edge.
  task automatic wait_valid(output int k);
    k = 0;
    while (k <= BUDGET) begin
      @(negedge clk);
      k++;
      if (mdu_result.valid) break;
    end
  endtask

  // Called at a negedge with the unit idle; leaves at a negedge with the unit idle again.
  task automatic run_vec(input string name, input vec_t v, input logic [5:0] tag,
                         input bit hold_gnt);
    int k;
    int lat;
    lat = (!v.f3[2]) ? 2 : ((EARLY_EN && v.early) ? 2 : 34);
    check({name, "_ready_in"}, 32'(issue_ready), 32'd1);
    issue_valid  = 1'b1;
    issue_funct3 = v.f3;
    issue_rs1    = v.a;
    issue_rs2    = v.b;
    issue_tag    = tag;
    mdu_cdb_gnt  = hold_gnt;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    wait_valid(k);
    check({name, "_lat"}, 32'(k), 32'(lat));
    check({name, "_data"}, mdu_result.data, v.exp);
    check({name, "_tag"}, 32'(mdu_result.tag), 32'(tag));
    mdu_cdb_gnt = 1'b1;
    @(negedge clk);
    mdu_cdb_gnt = 1'b0;
    check({name, "_ready_out"}, 32'(issue_ready), 32'd1);
    check({name, "_valid_drop"}, 32'(mdu_result.valid), 32'd0);
  endtask

  initial begin
    int k;
    bit seen;
    logic [31:0] val_sum;
    rst          = 1'b1;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_funct3 = '0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    issue_tag    = '0;
    mdu_cdb_gnt  = 1'b0;

    vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}); // MUL 7*-3
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}); // MULHU
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}); // MULH
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}); // MULHSU
    vecs.push_back('{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0}); // MUL 2^32 low
    vecs.push_back('{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0}); // MULHU 2^32 high
    vecs.push_back('{3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0}); // DIV -20/3
    vecs.push_back('{3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0}); // REM -20%3
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       1'b0}); // DIVU 100/7
    vecs.push_back('{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0}); // DIV 20/-3
    vecs.push_back('{3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        1'b0}); // REM 20%-3
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0}); // DIV -7/2
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0}); // REM -7%2
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0}); // DIVU big
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0}); // REMU big
    vecs.push_back('{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1}); // DIVU /0
    vecs.push_back('{3'b111, 32'h00000055, 32'd0,        32'h00000055, 1'b1}); // REMU /0
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1}); // DIV -7/0
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1}); // REM -7%0
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}); // DIV overflow
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}); // REM overflow
    vecs.push_back('{3'b101, 32'd5,        32'd9,        32'd0,        1'b1}); // DIVU small
    vecs.push_back('{3'b111, 32'd5,        32'd9,        32'd5,        1'b1}); // REMU small
    vecs.push_back('{3'b100, 32'd3,        32'hFFFFFFF9, 32'd0,        1'b1}); // DIV 3/-7
    vecs.push_back('{3'b110, 32'd3,        32'hFFFFFFF9, 32'd3,        1'b1}); // REM 3%-7

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(mdu_result.valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_result", 32'(mdu_result), 32'd0);

    // First vector holds grant high from the accept on: early grants must be ignored.
    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i], 6'(i + 1), i == 0);

    // Stall in DONE with grant low; further offers must be ignored.
    issue_valid = 1'b1; issue_funct3 = 3'b101; issue_rs1 = 32'd1000; issue_rs2 = 32'd10;
    issue_tag = 6'd9;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    wait_valid(k);
    check("stall_lat", 32'(k), 32'd34);
    val_sum = 32'd0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rs1 = 32'd3; issue_rs2 = 32'd3;
      issue_tag = 6'd10;
      @(negedge clk);
      check($sformatf("stall_data%0d", i), mdu_result.data, 32'd100);
      check($sformatf("stall_tag%0d", i), 32'(mdu_result.tag), 32'd9);
      check($sformatf("stall_valid%0d", i), 32'(mdu_result.valid), 32'd1);
      check($sformatf("stall_ready%0d", i), 32'(issue_ready), 32'd0);
    end
    issue_valid = 1'b0;
    mdu_cdb_gnt = 1'b1;
    @(negedge clk);
    mdu_cdb_gnt = 1'b0;
    check("stall_ready_out", 32'(issue_ready), 32'd1);
    check("stall_valid_drop", 32'(mdu_result.valid), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mdu_result.valid) seen = 1'b1;
    end
    check("stall_no_ghost", 32'(seen), 32'd0);

    // Flush at T+10 of a DIV together with a fresh offer.
    issue_valid = 1'b1; issue_funct3 = 3'b100; issue_rs1 = 32'hFFFFFFEC; issue_rs2 = 32'd3;
    issue_tag = 6'd12;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rs1 = 32'd5; issue_rs2 = 32'd6;
    issue_tag = 6'd13;
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    check("flush_ready", 32'(issue_ready), 32'd1);
    check("flush_valid", 32'(mdu_result.valid), 32'd0);
    seen = 1'b0;
    repeat (BUDGET) begin
      @(negedge clk);
      if (mdu_result.valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a divide.
    issue_valid = 1'b1; issue_funct3 = 3'b101; issue_rs1 = 32'd77; issue_rs2 = 32'd5;
    issue_tag = 6'd20;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(issue_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mdu_result.valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);

    run_vec("post", '{3'b101, 32'd100, 32'd7, 32'd14, 1'b0}, 6'd33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
